// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared definitions for the training data feeder
// Purpose: default sizes, FSM state encoding and the packed sample field order
//   used by training_data_feeder and sample_mem.
// Ports: none (package).
package feeder_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_N_W     = 33;
  localparam int DEF_EPOCH_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } feederState_t;

  // A stored sample is {x1, x2, t}; these are field slots counted from the LSB.
  localparam int X1_POS = 2;
  localparam int X2_POS = 1;
  localparam int T_POS  = 0;

endpackage

// File: rtl/sample_mem.sv
// rtl/sample_mem.sv - sample table, one synchronous write port and one asynchronous read port
// Purpose: DEPTH x WIDTH storage for {x1, x2, t} samples. Contents are not reset.
// Ports:
//   clk     in   rising-edge clock
//   wrEn    in   write strobe (already qualified by the caller)
//   wrAddr  in   write index
//   wrData  in   packed sample to store
//   rdAddr  in   read index
//   rdData  out  packed sample at rdAddr (combinational)
module sample_mem
  import feeder_pkg::*;
#(
  parameter int WIDTH  = 3 * DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [WIDTH-1:0]  rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/training_data_feeder.sv
// rtl/training_data_feeder.sv - sample source for the perceptron training controller
// Purpose: holds a table of (x1, x2, t) samples, launches a training run with a
//   one-cycle start pulse and a latched sample count, and answers each
//   readyToGetData request with the next sample, wrapping every epoch.
// Optional feature: define EPOCH_COUNT_EN to count completed table wraps on epochCnt.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   wrEn/wrAddr/wrData  host table load, accepted only while idle
//   sampleCount, go  run request; count must be 1..DEPTH
//   readyToGetData   controller asks for the next sample
//   doneSignal       controller finished training
//   start            one-cycle start pulse to the controller
//   nBus             sample count latched for the run
//   x1, x2, t        current sample (registered)
//   busy             high from ARM through FINISH
//   trainDone        one-cycle pulse after doneSignal
//   cfgErr           sticky bad-count flag, cleared by the next accepted go
//   epochCnt         completed table wraps (0 without EPOCH_COUNT_EN)
module training_data_feeder
  import feeder_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int N_W     = DEF_N_W,
  parameter int EPOCH_W = DEF_EPOCH_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrEn,
  input  logic [ADDR_W-1:0]     wrAddr,
  input  logic [3*DATA_W-1:0]   wrData,
  input  logic [N_W-1:0]        sampleCount,
  input  logic                  go,
  input  logic                  readyToGetData,
  input  logic                  doneSignal,
  output logic                  start,
  output logic [N_W-1:0]        nBus,
  output logic [DATA_W-1:0]     x1,
  output logic [DATA_W-1:0]     x2,
  output logic [DATA_W-1:0]     t,
  output logic                  busy,
  output logic                  trainDone,
  output logic                  cfgErr,
  output logic [EPOCH_W-1:0]    epochCnt
);

  localparam int W = 3 * DATA_W;

  feederState_t      state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptrNext;
  logic [ADDR_W-1:0] rdAddr;
  logic [W-1:0]      rdData;
  logic              countOk;
  logic              atLast;
  logic              memWe;
  logic              advance;

  assign countOk = (sampleCount != '0) && (sampleCount <= N_W'(DEPTH));
  assign atLast  = (N_W'(ptr) == (nBus - N_W'(1)));
  assign ptrNext = atLast ? '0 : ptr + ADDR_W'(1);
  // ARM preloads entry 0; in RUN the read port already looks at the next index.
  assign rdAddr  = (state == ARM) ? '0 : ptrNext;
  // Table is frozen outside IDLE so a run always replays the same data.
  assign memWe   = wrEn && (state == IDLE);
  // doneSignal wins over a same-cycle ready.
  assign advance = (state == RUN) && readyToGetData && !doneSignal;

  sample_mem #(
    .WIDTH (W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk   (clk),
    .wrEn  (memWe),
    .wrAddr(wrAddr),
    .wrData(wrData),
    .rdAddr(rdAddr),
    .rdData(rdData)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      start     <= 1'b0;
      busy      <= 1'b0;
      trainDone <= 1'b0;
      cfgErr    <= 1'b0;
      nBus      <= '0;
      x1        <= '0;
      x2        <= '0;
      t         <= '0;
    end else begin
      start     <= 1'b0;
      trainDone <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            if (countOk) begin
              nBus   <= sampleCount;
              cfgErr <= 1'b0;
              start  <= 1'b1;
              busy   <= 1'b1;
              state  <= ARM;
            end else begin
              cfgErr <= 1'b1;
            end
          end
        end
        ARM: begin
          ptr   <= '0;
          x1    <= rdData[X1_POS*DATA_W +: DATA_W];
          x2    <= rdData[X2_POS*DATA_W +: DATA_W];
          t     <= rdData[T_POS*DATA_W +: DATA_W];
          state <= RUN;
        end
        RUN: begin
          if (doneSignal) begin
            trainDone <= 1'b1;
            state     <= FINISH;
          end else if (advance) begin
            ptr <= ptrNext;
            x1  <= rdData[X1_POS*DATA_W +: DATA_W];
            x2  <= rdData[X2_POS*DATA_W +: DATA_W];
            t   <= rdData[T_POS*DATA_W +: DATA_W];
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EPOCH_COUNT_EN
  logic [EPOCH_W-1:0] epochReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      epochReg <= '0;
    end else if ((state == IDLE) && go && countOk) begin
      epochReg <= '0;
    end else if (advance && atLast && (epochReg != '1)) begin
      epochReg <= epochReg + EPOCH_W'(1);
    end
  end

  assign epochCnt = epochReg;
`else
  assign epochCnt = '0;
`endif

endmodule

// File: tb/tb_training_data_feeder.sv
// tb/tb_training_data_feeder.sv - self-checking bench for training_data_feeder
module tb_training_data_feeder;

  localparam int DATA_W  = 16;
  localparam int DEPTH   = 256;
  localparam int ADDR_W  = 8;
  localparam int N_W     = 33;
  localparam int EPOCH_W = 16;
  localparam int W       = 3 * DATA_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                wrEn;
  logic [ADDR_W-1:0]   wrAddr;
  logic [W-1:0]        wrData;
  logic [N_W-1:0]      sampleCount;
  logic                go;
  logic                readyToGetData;
  logic                doneSignal;
  logic                start;
  logic [N_W-1:0]      nBus;
  logic [DATA_W-1:0]   x1, x2, t;
  logic                busy;
  logic                trainDone;
  logic                cfgErr;
  logic [EPOCH_W-1:0]  epochCnt;

  always #5 clk = ~clk;

  training_data_feeder dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .sampleCount(sampleCount), .go(go), .readyToGetData(readyToGetData),
    .doneSignal(doneSignal), .start(start), .nBus(nBus), .x1(x1), .x2(x2), .t(t),
    .busy(busy), .trainDone(trainDone), .cfgErr(cfgErr), .epochCnt(epochCnt)
  );

  typedef struct {
    logic [N_W-1:0] count;
    logic           expStart;
    logic           expErr;
  } goVec_t;

  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] mdl [DEPTH];
  int           idx;
  longint       n;
  int           epochs;
  goVec_t       goTab [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] expEpoch();
`ifdef EPOCH_COUNT_EN
    return 64'(epochs);
`else
    return 64'd0;
`endif
  endfunction

  task automatic writeEntry(input logic [ADDR_W-1:0] a, input logic [W-1:0] d);
    wrEn = 1'b1; wrAddr = a; wrData = d;
    step();
    wrEn = 1'b0;
  endtask

  task automatic startRun(input logic [N_W-1:0] count);
    sampleCount = count; go = 1'b1;
    step();
    go = 1'b0;
    chk("arm_start", 64'(start), 64'd1);
    chk("arm_busy", 64'(busy), 64'd1);
    chk("arm_nbus", 64'(nBus), 64'(count));
    step();
    chk("run_start_low", 64'(start), 64'd0);
    idx = 0; n = longint'(count); epochs = 0;
    chk("run_sample0", 64'({x1, x2, t}), 64'(mdl[0]));
  endtask

  // Model: index advances by one and wraps to 0 after n-1.
  task automatic modelAdvance();
    if (longint'(idx) + 1 == n) begin
      idx = 0;
      epochs++;
    end else begin
      idx++;
    end
  endtask

  task automatic readyPulse();
    readyToGetData = 1'b1;
    step();
    readyToGetData = 1'b0;
    modelAdvance();
    chk("ready_sample", 64'({x1, x2, t}), 64'(mdl[idx]));
    chk("ready_epoch", 64'(epochCnt), expEpoch());
  endtask

  task automatic finishRun();
    doneSignal = 1'b1;
    step();
    doneSignal = 1'b0;
    chk("finish_traindone", 64'(trainDone), 64'd1);
    chk("finish_busy", 64'(busy), 64'd1);
    step();
    chk("idle_traindone", 64'(trainDone), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; wrEn = 1'b0; wrAddr = '0; wrData = '0; sampleCount = '0;
    go = 1'b0; readyToGetData = 1'b0; doneSignal = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_traindone", 64'(trainDone), 64'd0);
    chk("rst_cfgerr", 64'(cfgErr), 64'd0);
    chk("rst_nbus", 64'(nBus), 64'd0);
    chk("rst_sample", 64'({x1, x2, t}), 64'd0);
    chk("rst_epoch", 64'(epochCnt), 64'd0);

    for (int i = 0; i < DEPTH; i++) begin
      mdl[i] = W'({$urandom, $urandom});
      writeEntry(ADDR_W'(i), mdl[i]);
    end

    // Basic run: three samples, four ready pulses walking s1 s2 s0 s1.
    startRun(33'd3);
    for (int i = 0; i < 4; i++) readyPulse();
    // doneSignal with a same-cycle ready: ready is dropped.
    doneSignal = 1'b1; readyToGetData = 1'b1;
    step();
    doneSignal = 1'b0; readyToGetData = 1'b0;
    chk("done_pri_traindone", 64'(trainDone), 64'd1);
    chk("done_pri_sample", 64'({x1, x2, t}), 64'(mdl[idx]));
    step();
    chk("done_pri_traindone_low", 64'(trainDone), 64'd0);
    chk("done_pri_busy", 64'(busy), 64'd0);
    chk("done_pri_hold", 64'({x1, x2, t}), 64'(mdl[idx]));

    // Count validation table.
    goTab[0] = '{33'd0,           1'b0, 1'b1};
    goTab[1] = '{33'd1,           1'b1, 1'b0};
    goTab[2] = '{33'd257,         1'b0, 1'b1};
    goTab[3] = '{33'd256,         1'b1, 1'b0};
    goTab[4] = '{33'h1_0000_0000, 1'b0, 1'b1};
    goTab[5] = '{33'h1_0000_0001, 1'b0, 1'b1};
    goTab[6] = '{33'd7,           1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      sampleCount = goTab[i].count; go = 1'b1;
      step();
      go = 1'b0;
      chk("tab_start", 64'(start), 64'(goTab[i].expStart));
      chk("tab_cfgerr", 64'(cfgErr), 64'(goTab[i].expErr));
      chk("tab_busy", 64'(busy), 64'(goTab[i].expStart));
      step();
      if (goTab[i].expStart) begin
        chk("tab_sample0", 64'({x1, x2, t}), 64'(mdl[0]));
        finishRun();
      end else begin
        chk("tab_idle_busy", 64'(busy), 64'd0);
        chk("tab_idle_start", 64'(start), 64'd0);
        chk("tab_err_sticky", 64'(cfgErr), 64'd1);
      end
    end

    // Single-sample run: every ready reloads entry 0.
    startRun(33'd1);
    for (int i = 0; i < 3; i++) readyPulse();
    finishRun();

    // Reset mid-run, then restart with table intact.
    startRun(33'd5);
    readyPulse();
    readyPulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_start", 64'(start), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_nbus", 64'(nBus), 64'd0);
    chk("midrst_sample", 64'({x1, x2, t}), 64'd0);
    chk("midrst_epoch", 64'(epochCnt), 64'd0);
    chk("midrst_traindone", 64'(trainDone), 64'd0);
    startRun(33'd4);
    readyPulse();
    finishRun();

    // A write during RUN is dropped.
    startRun(33'd2);
    writeEntry(ADDR_W'(0), ~mdl[0]);
    chk("wr_run_hold", 64'({x1, x2, t}), 64'(mdl[0]));
    readyPulse();
    readyPulse();
    finishRun();
    startRun(33'd1);
    finishRun();

    // Randomized runs against the model.
    for (int r = 0; r < 16; r++) begin
      int cnt;
      int cyc;
      for (int k = 0; k < 3; k++) begin
        int a;
        a = int'($urandom_range(0, DEPTH - 1));
        mdl[a] = W'({$urandom, $urandom});
        writeEntry(ADDR_W'(a), mdl[a]);
      end
      cnt = (r == 5) ? DEPTH : int'($urandom_range(1, 12));
      cyc = 2 * cnt + 10;
      startRun(N_W'(cnt));
      for (int c = 0; c < cyc; c++) begin
        readyToGetData = $urandom_range(0, 1) == 1;
        wrEn   = $urandom_range(0, 3) == 0;
        wrAddr = ADDR_W'($urandom);
        wrData = W'({$urandom, $urandom});
        step();
        if (readyToGetData) modelAdvance();
        readyToGetData = 1'b0;
        wrEn = 1'b0;
        chk("rand_sample", 64'({x1, x2, t}), 64'(mdl[idx]));
        chk("rand_epoch", 64'(epochCnt), expEpoch());
      end
      chk("rand_nbus", 64'(nBus), 64'(cnt));
      finishRun();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
